// File: rtl/pkt_meter_pkg.sv
// Shared types and helpers for the AXI-Stream packet length meter.
package pkt_meter_pkg;

  localparam int REC_FIELD_W = 32;

  typedef struct packed {
    logic [REC_FIELD_W-1:0] bytes;
    logic [REC_FIELD_W-1:0] flits;
    logic                   sat;
  } pkt_len_rec_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } meter_state_e;

  // Bits needed to hold a popcount of 0..tkeep_w.
  function automatic int bc_width(input int tkeep_w);
    return $clog2(tkeep_w + 1);
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational popcount of a keep vector as a balanced binary adder tree.
module keep_popcount
  import pkt_meter_pkg::*;
#(
  parameter int TKEEP_WIDTH = 8,
  localparam int BC_W = bc_width(TKEEP_WIDTH)
) (
  input  logic [TKEEP_WIDTH-1:0] keep,
  output logic [BC_W-1:0]        count
);

  localparam int LEAVES = 1 << $clog2(TKEEP_WIDTH);
  localparam int NODES  = 2 * LEAVES - 1;

  logic [LEAVES-1:0] keep_pad;
  logic [BC_W-1:0]   node [NODES];

  assign keep_pad = LEAVES'(keep);

  // Heap layout: leaves at LEAVES-1.., node k sums children 2k+1 and 2k+2.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) node[LEAVES-1+i] = BC_W'(keep_pad[i]);
    for (int k = LEAVES - 2; k >= 0; k--) node[k] = node[2*k+1] + node[2*k+2];
  end

  assign count = node[0];

endmodule

// File: rtl/pkt_length_meter.sv
// Passive AXI-Stream length meter: per-beat byte counts and buffered
// per-packet byte/flit totals with saturation and drop accounting.
module pkt_length_meter
  import pkt_meter_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16,
  parameter int FLIT_WIDTH  = 12,
  parameter int FIFO_DEPTH  = 4,
  localparam int BC_W = bc_width(TKEEP_WIDTH)
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   s_tvalid,
  input  logic                   s_tready,
  input  logic [TKEEP_WIDTH-1:0] s_tkeep,
  input  logic                   s_tlast,
  output logic [BC_W-1:0]        bytes_in_flit,
  output logic                   bytes_valid,
  output logic                   in_packet,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [LEN_WIDTH-1:0]   rec_bytes,
  output logic [FLIT_WIDTH-1:0]  rec_flits,
  output logic                   rec_sat,
  output logic [15:0]            drop_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int LW1 = LEN_WIDTH + 1;
  localparam int FW1 = FLIT_WIDTH + 1;
  localparam logic [REC_FIELD_W-1:0] BYTES_MAX = REC_FIELD_W'({LEN_WIDTH{1'b1}});
  localparam logic [REC_FIELD_W-1:0] FLITS_MAX = REC_FIELD_W'({FLIT_WIDTH{1'b1}});

  meter_state_e          state_reg, state_next;
  logic                  beat, push_req, push_ok, pop, full, empty;
  logic [BC_W-1:0]       pop_count, bytes_in_flit_reg;
  logic                  bytes_valid_reg;
  logic [LEN_WIDTH-1:0]  acc_bytes_reg, bytes_total;
  logic [FLIT_WIDTH-1:0] acc_flits_reg, flits_total;
  logic                  acc_sat_reg, sat_total;
  logic [LW1-1:0]        bytes_sum;
  logic [FW1-1:0]        flits_sum;
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [15:0]           drop_count_reg;
  pkt_len_rec_t          mem [FIFO_DEPTH];
  pkt_len_rec_t          push_rec, head;

  keep_popcount #(.TKEEP_WIDTH(TKEEP_WIDTH)) u_popcount (
    .keep  (s_tkeep),
    .count (pop_count)
  );

  assign beat = s_tvalid & s_tready;

  always_comb begin
    state_next = state_reg;
    if (beat) state_next = s_tlast ? IDLE : IN_PKT;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Totals including the current beat; the carry-out bit flags overflow.
  always_comb begin
    bytes_sum   = {1'b0, acc_bytes_reg} + LW1'(pop_count);
    flits_sum   = {1'b0, acc_flits_reg} + FW1'(1);
    bytes_total = bytes_sum[LEN_WIDTH] ? '1 : bytes_sum[LEN_WIDTH-1:0];
    flits_total = flits_sum[FLIT_WIDTH] ? '1 : flits_sum[FLIT_WIDTH-1:0];
    sat_total   = acc_sat_reg | bytes_sum[LEN_WIDTH] | flits_sum[FLIT_WIDTH];
    push_rec.bytes = REC_FIELD_W'(bytes_total);
    push_rec.flits = REC_FIELD_W'(flits_total);
    push_rec.sat   = sat_total;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bytes_in_flit_reg <= '0;
      bytes_valid_reg   <= 1'b0;
      acc_bytes_reg     <= '0;
      acc_flits_reg     <= '0;
      acc_sat_reg       <= 1'b0;
    end else begin
      bytes_valid_reg <= beat;
      if (beat) begin
        bytes_in_flit_reg <= pop_count;
        if (s_tlast) begin
          acc_bytes_reg <= '0;
          acc_flits_reg <= '0;
          acc_sat_reg   <= 1'b0;
        end else begin
          acc_bytes_reg <= bytes_total;
          acc_flits_reg <= flits_total;
          acc_sat_reg   <= sat_total;
        end
      end
    end
  end

  // Record FIFO: pointers carry an extra wrap bit to tell full from empty.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rec_valid = !empty;
  assign pop      = rec_valid & rec_ready;
  assign push_req = beat & s_tlast;
  assign push_ok  = push_req & (!full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_rec;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      drop_count_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push_req && !push_ok && drop_count_reg != 16'hFFFF)
        drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  // Stored fields never exceed the configured maxima; the clamp only narrows.
  assign head      = mem[rd_ptr_reg[AW-1:0]];
  assign rec_bytes = !rec_valid ? '0 :
                     (head.bytes > BYTES_MAX) ? '1 : LEN_WIDTH'(head.bytes);
  assign rec_flits = !rec_valid ? '0 :
                     (head.flits > FLITS_MAX) ? '1 : FLIT_WIDTH'(head.flits);
  assign rec_sat   = rec_valid & head.sat;

  assign bytes_in_flit = bytes_in_flit_reg;
  assign bytes_valid   = bytes_valid_reg;
  assign in_packet     = (state_reg == IN_PKT);
  assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_pkt_length_meter.sv
// Self-checking bench for pkt_length_meter: directed tables, corner sequences
// and random traffic against a packet-level reference model.
module tb_pkt_length_meter;

  localparam int KW    = 8;
  localparam int BCW   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  logic s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0, rec_ready = 1'b0;
  logic [KW-1:0] s_tkeep = '0;

  logic [BCW-1:0] o_bif, d8_bif;
  logic o_bv, d8_bv, o_inp, d8_inp, o_rv, d8_rv, o_sat, d8_sat;
  logic [15:0] o_bytes;
  logic [7:0]  d8_bytes;
  logic [11:0] o_flits, d8_flits;
  logic [15:0] o_drop, d8_drop;

  int total = 0;
  int bad   = 0;

  typedef struct {int b; int f;} mrec_t;
  mrec_t q[$];
  int m_bif, m_bv, m_inp, m_acc_b, m_acc_f, m_drop;

  typedef struct {logic [7:0] keep; int exp_bif;} kvec_t;

  always #5 clk = ~clk;

  pkt_length_meter #(.TDATA_WIDTH(64)) dut (
    .clk(clk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .bytes_in_flit(o_bif), .bytes_valid(o_bv),
    .in_packet(o_inp), .rec_valid(o_rv), .rec_ready(rec_ready), .rec_bytes(o_bytes),
    .rec_flits(o_flits), .rec_sat(o_sat), .drop_count(o_drop)
  );

  pkt_length_meter #(.TDATA_WIDTH(64), .LEN_WIDTH(8)) dut8 (
    .clk(clk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .bytes_in_flit(d8_bif), .bytes_valid(d8_bv),
    .in_packet(d8_inp), .rec_valid(d8_rv), .rec_ready(rec_ready), .rec_bytes(d8_bytes),
    .rec_flits(d8_flits), .rec_sat(d8_sat), .drop_count(d8_drop)
  );

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts the state after the coming clock edge from the current inputs.
  task automatic model_step();
    bit beat, pop, full;
    int pc;
    beat = s_tvalid && s_tready;
    pop  = (q.size() > 0) && rec_ready;
    full = (q.size() >= DEPTH);
    m_bv = beat;
    if (pop) void'(q.pop_front());
    if (beat) begin
      pc = $countones(s_tkeep);
      m_bif = pc;
      m_acc_b += pc;
      m_acc_f += 1;
      if (s_tlast) begin
        if (!full || pop) begin
          q.push_back('{m_acc_b, m_acc_f});
          $display("pkt done: bytes=%0d flits=%0d queued", m_acc_b, m_acc_f);
        end else begin
          if (m_drop < 65535) m_drop++;
          $display("pkt done: bytes=%0d flits=%0d dropped", m_acc_b, m_acc_f);
        end
        m_acc_b = 0;
        m_acc_f = 0;
        m_inp = 0;
      end else begin
        m_inp = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("bytes_in_flit", o_bif, m_bif);
    chk("bytes_valid", o_bv, m_bv);
    chk("in_packet", o_inp, m_inp);
    chk("rec_valid", o_rv, q.size() > 0);
    chk("drop_count", o_drop, m_drop);
    chk("d8_bytes_in_flit", d8_bif, m_bif);
    chk("d8_in_packet", d8_inp, m_inp);
    chk("d8_rec_valid", d8_rv, q.size() > 0);
    chk("d8_drop_count", d8_drop, m_drop);
    if (q.size() > 0) begin
      chk("rec_bytes", o_bytes, clampi(q[0].b, 65535));
      chk("rec_flits", o_flits, clampi(q[0].f, 4095));
      chk("rec_sat", o_sat, (q[0].b > 65535) || (q[0].f > 4095));
      chk("d8_rec_bytes", d8_bytes, clampi(q[0].b, 255));
      chk("d8_rec_flits", d8_flits, clampi(q[0].f, 4095));
      chk("d8_rec_sat", d8_sat, (q[0].b > 255) || (q[0].f > 4095));
    end
  endtask

  task automatic drive(input bit v, input bit r, input logic [7:0] k, input bit l);
    s_tvalid = v;
    s_tready = r;
    s_tkeep  = k;
    s_tlast  = l;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_tvalid = 0; s_tready = 0; s_tkeep = '0; s_tlast = 0; rec_ready = 0;
    @(negedge clk);
    chk("rst_bytes_in_flit", o_bif, 0);
    chk("rst_bytes_valid", o_bv, 0);
    chk("rst_in_packet", o_inp, 0);
    chk("rst_rec_valid", o_rv, 0);
    chk("rst_rec_bytes", o_bytes, 0);
    chk("rst_rec_flits", o_flits, 0);
    chk("rst_rec_sat", o_sat, 0);
    chk("rst_drop_count", o_drop, 0);
    chk("rst_d8_rec_valid", d8_rv, 0);
    chk("rst_d8_rec_bytes", d8_bytes, 0);
    q.delete();
    m_bif = 0; m_bv = 0; m_inp = 0; m_acc_b = 0; m_acc_f = 0; m_drop = 0;
    aresetn = 1'b1;
  endtask

  initial begin
    kvec_t t1 [4];
    t1[0] = '{8'hFF, 8};
    t1[1] = '{8'h0F, 4};
    t1[2] = '{8'h81, 2};
    t1[3] = '{8'h00, 0};

    #1;
    do_reset();

    // Keep decode: single-beat packets
    rec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, t1[i].keep, 1);
      chk("t1_bif", o_bif, t1[i].exp_bif);
      chk("t1_bv_pulse", o_bv, 1);
      drive(0, 0, 8'h00, 0);
      chk("t1_bv_low", o_bv, 0);
      chk("t1_bif_hold", o_bif, t1[i].exp_bif);
    end

    // Multi-beat packet
    drive(1, 1, 8'hFF, 0);
    chk("t2_inpkt_after_b1", o_inp, 1);
    drive(1, 1, 8'hFF, 0);
    chk("t2_inpkt_b3_cycle", o_inp, 1);
    drive(1, 1, 8'h0F, 1);
    chk("t2_rec_valid", o_rv, 1);
    chk("t2_rec_bytes", o_bytes, 20);
    chk("t2_rec_flits", o_flits, 3);
    chk("t2_rec_sat", o_sat, 0);
    chk("t2_inpkt_end", o_inp, 0);
    drive(0, 0, 8'h00, 0);
    chk("t2_rec_valid_once", o_rv, 0);

    // Back-pressure and drop
    do_reset();
    rec_ready = 0;
    drive(1, 1, 8'h01, 1);
    drive(1, 1, 8'h03, 1);
    drive(1, 1, 8'h07, 1);
    drive(1, 1, 8'h0F, 1);
    drive(1, 1, 8'h1F, 1);
    chk("t3_drop", o_drop, 1);
    rec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order_valid", o_rv, 1);
      chk("t3_order_bytes", o_bytes, i + 1);
      drive(0, 0, 8'h00, 0);
    end
    chk("t3_drained", o_rv, 0);

    // Saturation on the 8-bit length instance
    do_reset();
    rec_ready = 1;
    for (int i = 0; i < 40; i++) drive(1, 1, 8'hFF, i == 39);
    chk("t4_d8_bytes", d8_bytes, 255);
    chk("t4_d8_flits", d8_flits, 40);
    chk("t4_d8_sat", d8_sat, 1);
    chk("t4_bytes16", o_bytes, 320);
    chk("t4_sat16", o_sat, 0);
    drive(1, 1, 8'hFF, 1);
    chk("t4_next_bytes", d8_bytes, 8);
    chk("t4_next_sat", d8_sat, 0);

    // Reset mid-packet
    do_reset();
    drive(1, 1, 8'hFF, 0);
    drive(1, 1, 8'hFF, 0);
    do_reset();
    drive(1, 1, 8'h03, 1);
    chk("t5_rec_valid", o_rv, 1);
    chk("t5_rec_bytes", o_bytes, 2);
    chk("t5_rec_flits", o_flits, 1);
    rec_ready = 1;
    drive(0, 0, 8'h00, 0);
    chk("t5_single_rec", o_rv, 0);

    // Stall gaps: ready toggles, tlast also raised on a stalled cycle
    do_reset();
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, (i % 2) == 0, 8'hFF, i >= 5);
      if (i == 6) begin
        chk("t6_rec_bytes", o_bytes, 32);
        chk("t6_rec_flits", o_flits, 4);
      end
    end

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      rec_ready = ((i / 60) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            8'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_length_meter.md
# pkt_length_meter

Passive AXI-Stream length meter for the packet snooper in the traffic monitor. It turns every accepted beat's `tkeep` into a byte count for any bus width, accumulates byte and flit totals per packet, and emits one length record per packet on a buffered valid/ready interface. It replaces the fixed 16-bit keep decoder. It never drives the snooped stream and never back-pressures it.

## Interface
Parameters:
- `TDATA_WIDTH`, 64: width of the snooped data bus; a multiple of 8, minimum 8.
- `TKEEP_WIDTH`, `TDATA_WIDTH/8`: keep width.
- `LEN_WIDTH`, 16: width of the per-packet byte total.
- `FLIT_WIDTH`, 12: width of the per-packet flit total.
- `FIFO_DEPTH`, 4: record buffer depth; a power of 2, ≥2.

Ports (`BC_W = $clog2(TKEEP_WIDTH+1)`):
- `clk` in 1: the single clock.
- `aresetn` in 1: reset, asynchronous and active-low.
- `s_tvalid` in 1: snooped valid.
- `s_tready` in 1: snooped ready.
- `s_tkeep` in `TKEEP_WIDTH`: snooped keep.
- `s_tlast` in 1: snooped last.
- `bytes_in_flit` out `BC_W`: byte count of the most recent beat.
- `bytes_valid` out 1: one-cycle pulse when `bytes_in_flit` is updated.
- `in_packet` out 1: high while a packet is open.
- `rec_valid` out 1: a length record is available.
- `rec_ready` in 1: the consumer accepts the record.
- `rec_bytes` out `LEN_WIDTH`: packet byte total.
- `rec_flits` out `FLIT_WIDTH`: packet flit total.
- `rec_sat` out 1: one of the two totals saturated.
- `drop_count` out 16: number of records lost because the buffer was full; saturates.

## Operation
- **Beat.** A beat is `s_tvalid & s_tready`. No other input combination changes state.
- **Byte count.** The byte count is the popcount of `s_tkeep`. Non-contiguous keeps count their set bits, so `2'b10` counts as 1. An all-zero keep counts 0 bytes but still counts as one flit.
- **Per-beat output.** On every beat, `bytes_in_flit` takes that beat's popcount and `bytes_valid` pulses. `bytes_in_flit` holds its value between beats.
- **FSM states.**
  - IDLE → IN_PKT on a beat with `s_tlast` low.
  - IN_PKT → IDLE on a beat with `s_tlast` high.
  - A single-beat packet (a beat in IDLE with `s_tlast` high) stays in IDLE.
  - `in_packet` is 1 exactly when the state is IN_PKT.
- **Accumulators.**
  - On a non-last beat: `acc_bytes += popcount`, `acc_flits += 1`.
  - On a last beat: the record is the accumulated totals including this beat. The accumulators then clear to 0 on the same edge.
  - Both totals saturate at all-ones and never wrap. A sticky saturation flag is set when either would have overflowed. It is carried into the record as `rec_sat` and cleared with the accumulators.
- **Record buffer.**
  - FIFO of `FIFO_DEPTH` entries, show-ahead: `rec_*` always shows the head entry.
  - Pop happens when `rec_valid & rec_ready`.
  - A push happens on a last beat. It is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle (occupancy unchanged).
  - Otherwise the record is discarded and `drop_count` increments, saturating at 16'hFFFF.
  - `rec_*` values are stable while `rec_valid & !rec_ready`.
- **Handshake.** `rec_valid` never depends combinationally on `rec_ready`.

## Timing
- **Reset values.** While `aresetn` is low, all outputs are 0: `bytes_in_flit`, `bytes_valid`, `in_packet`, `rec_valid`, `rec_bytes`, `rec_flits`, `rec_sat`, `drop_count`. The FIFO is empty, the FSM is in IDLE, and the accumulators are 0.
- **Reset mid-packet.** The partial packet is discarded and no record is produced. The first beat after reset starts a new packet, even if the snooped source was mid-packet.
- **Per-beat latency.** `bytes_in_flit` and `bytes_valid` are registered and appear 1 cycle after the beat edge.
- **Record latency.**
  - A record pushed on the last-beat edge drives `rec_valid` from the next cycle when the FIFO was empty.
  - Otherwise it appears after the entries ahead of it are popped.
- **Throughput.**
  - One beat per cycle is sustained, including back-to-back single-beat packets.
  - One record per cycle can be pushed and popped simultaneously.
- **Idle inputs.** With `s_tvalid` high and `s_tready` low, nothing happens.

## Structure
- **Shared package** `pkt_meter_pkg`:
  - typedef `pkt_len_rec_t`, a struct of bytes, flits and sat;
  - enum `meter_state_e` with values IDLE and IN_PKT;
  - a function `bc_width(tkeep_w)`.
- **Sub-module** `keep_popcount`, parameterised by `TKEEP_WIDTH`: a purely combinational adder tree over the keep bits.
- **FIFO.** Inline in the top module: a circular buffer with read/write pointers one bit wider than the address.

## Test plan
All scenarios use `TDATA_WIDTH=64`.
1. **Keep decode.** Single beats with keep 8'hFF, 8'h0F, 8'h81, 8'h00 → `bytes_in_flit` 8, 4, 2, 0, each one cycle after its beat with a `bytes_valid` pulse.
2. **Multi-beat packet.** Keeps FF, FF, 0F with `s_tlast` on the third beat, `rec_ready` high → `rec_bytes`=20, `rec_flits`=3, `rec_sat`=0. `rec_valid` is high for exactly one cycle; `in_packet` is high from the cycle after beat 1 through the cycle of beat 3.
3. **Back-pressure and drop.** `rec_ready`=0, send 5 single-beat packets → 4 records held in order, `drop_count`=1. Then release `rec_ready` → 4 pops over 4 cycles.
4. **Saturation.** `LEN_WIDTH`=8, send 40 beats of FF (320 bytes) → `rec_bytes`=255, `rec_flits`=40, `rec_sat`=1. The next packet then reports `rec_sat`=0.
5. **Reset mid-packet.** 2 beats sent, `aresetn` pulsed low, then a single-beat packet with keep 8'h03 → exactly one record: `rec_bytes`=2, `rec_flits`=1. All outputs are 0 during reset.
6. **Stall gaps.** `s_tvalid` high with `s_tready` toggling 1010 → only cycles with `s_tready` high count; totals match only the accepted beats.
